mem_access_unit: RTL and testbench

//  Load/store front end placed directly upstream of the 1 KiB data memory dm_1k.

---
 rtl/mem_access_unit_pkg.sv | 43 ++++
 rtl/mem_access_unit_if.sv | 25 ++
 rtl/mem_access_unit_load_extend.sv | 32 +++
 rtl/mem_access_unit.sv | 120 ++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store front end: size codes, FSM states,
// and the legality / store-merge helpers used by mem_access_unit.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_t;

    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Replace the addressed byte/half of an existing word with new store data.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] m;
        m = word;
        case (size)
            SZ_BYTE: m[{off, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: m[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: m = wdata;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU-side request/response bundle of the load/store front end.
interface mem_access_unit_if #(
    parameter int AW = 10
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Selects the addressed byte/half lane of a memory word and sign/zero-extends it.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ext
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sgn;

    always_comb begin
        byte_v = word[{offset, 3'b000} +: 8];
        half_v = word[{offset[1], 4'b0000} +: 16];
        sgn    = 1'b0;
        ext    = word;
        case (size)
            SZ_BYTE: begin
                sgn = byte_v[7] & ~is_unsigned;
                ext = {{24{sgn}}, byte_v};
            end
            SZ_HALF: begin
                sgn = half_v[15] & ~is_unsigned;
                ext = {{16{sgn}}, half_v};
            end
            default: ext = word;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-wide dm_1k: byte/half loads are extracted
// and extended, byte/half stores are done as a read-modify-write of the word.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_access_unit_if.slave    bus,
    output logic [AW-1:0]       dm_addr,
    output logic [31:0]         dm_din,
    output logic                dm_we,
    input  logic [31:0]         dm_dout
);
    state_t        state, state_nxt;
    logic          we_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   merge_q;
    logic [31:0]   load_val;
    logic [AW-1:0] base;
    logic          accept;
    logic          illegal_in;

    assign base       = {addr_q[AW-1:2], 2'b00};
    assign accept     = (state == ST_IDLE) && bus.req_valid;
    assign illegal_in = req_illegal(bus.req_size, bus.req_addr[1:0]);

    load_extend u_load_extend (
        .word        (dm_dout),
        .offset      (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ext         (load_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // All memory-facing outputs decode straight from the state register, so an
    // async reset removes dm_we immediately and aborts a pending RMW write.
    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        dm_addr        = '0;
        dm_we          = 1'b0;
        dm_din         = '0;
        case (state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (illegal_in)
                        state_nxt = ST_RESP;
                    else if (bus.req_we && (bus.req_size != SZ_WORD))
                        state_nxt = ST_RMW_RD;
                    else
                        state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                dm_addr = base;
                if (we_q) begin
                    dm_we  = 1'b1;
                    dm_din = wdata_q;
                end
                state_nxt = ST_RESP;
            end
            ST_RMW_RD: begin
                dm_addr   = base;
                state_nxt = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                dm_addr   = base;
                dm_we     = 1'b1;
                dm_din    = merge_lane(merge_q, wdata_q, size_q, addr_q[1:0]);
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Response registers hold until the next accept; stores and errors report 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else if (accept) begin
            bus.resp_rdata <= '0;
            bus.resp_err   <= illegal_in;
        end else if ((state == ST_ACCESS) && !we_q) begin
            bus.resp_rdata <= load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
        if (state == ST_RMW_RD) begin
            merge_q <= dm_dout;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit attached to a behavioural dm_1k model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int AW = 10;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_din;
    logic [31:0]   dm_dout;
    logic          dm_we;
    logic [7:0]    mem [0:(1<<AW)-1];
    int            we_cnt = 0;
    int            vectors = 0;
    int            miscompares = 0;
    exp_t          sb_q[$];

    always #5 clk = ~clk;

    mem_access_unit_if #(.AW(AW)) bus ();

    mem_access_unit #(.AW(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .dm_addr (dm_addr),
        .dm_din  (dm_din),
        .dm_we   (dm_we),
        .dm_dout (dm_dout)
    );

    // dm_1k: combinational little-endian read, word write on the rising edge
    assign dm_dout = {mem[{dm_addr[AW-1:2], 2'd3}], mem[{dm_addr[AW-1:2], 2'd2}],
                      mem[{dm_addr[AW-1:2], 2'd1}], mem[{dm_addr[AW-1:2], 2'd0}]};

    always @(posedge clk) begin
        if (dm_we) begin
            mem[{dm_addr[AW-1:2], 2'd0}] <= dm_din[7:0];
            mem[{dm_addr[AW-1:2], 2'd1}] <= dm_din[15:8];
            mem[{dm_addr[AW-1:2], 2'd2}] <= dm_din[23:16];
            mem[{dm_addr[AW-1:2], 2'd3}] <= dm_din[31:24];
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request through the handshake; optionally pokes a store while busy.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input bit poke);
        exp_t e;
        exp_t got;
        int   lat;
        logic illegal;
        illegal = (size == 2'b11) || ((size == SZ_HALF) && addr[0]) ||
                  ((size == SZ_WORD) && (addr[1:0] != 2'b00));
        e.rdata = (we || illegal) ? 32'h0 : exp_rdata;
        e.err   = illegal;
        e.lat   = illegal ? 0 : ((we && (size != SZ_WORD)) ? 2 : 1);
        sb_q.push_back(e);

        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(bus.req_ready), 32'h1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (poke) begin
            chk({tag, "_ready_busy"}, 32'(bus.req_ready), 32'h0);
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_size  = SZ_WORD;
            bus.req_addr  = AW'(10'h100);
            bus.req_wdata = 32'hDEADBEEF;
        end
        lat = 0;
        while (!bus.resp_valid && lat < 8) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
            lat++;
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_underflow"}, 32'h1, 32'h0);
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_rdata"}, bus.resp_rdata, got.rdata);
            chk({tag, "_err"}, 32'(bus.resp_err), 32'(got.err));
            chk({tag, "_latency"}, 32'(lat), 32'(got.lat));
        end
        @(posedge clk);
        #1;
        chk({tag, "_pulse_end"}, 32'(bus.resp_valid), 32'h0);
        chk({tag, "_ready_after"}, 32'(bus.req_ready), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = SZ_WORD;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_rdata", bus.resp_rdata, 32'h0);
        chk("rst_err", 32'(bus.resp_err), 32'h0);
        chk("rst_dm_we", 32'(dm_we), 32'h0);
        chk("rst_dm_addr", 32'(dm_addr), 32'h0);
        chk("rst_dm_din", dm_din, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // word store, then loads of various lanes
        do_req("sw0",  1'b1, SZ_WORD, 1'b0, 10'd0, 32'h12345678, 32'h0, 1'b0);
        do_req("lw0",  1'b0, SZ_WORD, 1'b0, 10'd0, 32'h0, 32'h12345678, 1'b0);
        do_req("lbu1", 1'b0, SZ_BYTE, 1'b1, 10'd1, 32'h0, 32'h00000056, 1'b0);
        do_req("lb3",  1'b0, SZ_BYTE, 1'b0, 10'd3, 32'h0, 32'h00000012, 1'b0);

        // byte store read-modify-write
        do_req("sb2",  1'b1, SZ_BYTE, 1'b0, 10'd2, 32'hFFFFFF80, 32'h0, 1'b0);
        do_req("lw0b", 1'b0, SZ_WORD, 1'b0, 10'd0, 32'h0, 32'h12805678, 1'b0);
        do_req("lb2",  1'b0, SZ_BYTE, 1'b0, 10'd2, 32'h0, 32'hFFFFFF80, 1'b0);
        do_req("lbu2", 1'b0, SZ_BYTE, 1'b1, 10'd2, 32'h0, 32'h00000080, 1'b0);

        // half store read-modify-write
        do_req("sw4",  1'b1, SZ_WORD, 1'b0, 10'd4, 32'h12345678, 32'h0, 1'b0);
        do_req("sh6",  1'b1, SZ_HALF, 1'b0, 10'd6, 32'h0000BEEF, 32'h0, 1'b0);
        do_req("lw4",  1'b0, SZ_WORD, 1'b0, 10'd4, 32'h0, 32'hBEEF5678, 1'b0);
        do_req("lh6",  1'b0, SZ_HALF, 1'b0, 10'd6, 32'h0, 32'hFFFFBEEF, 1'b0);
        do_req("lhu6", 1'b0, SZ_HALF, 1'b1, 10'd6, 32'h0, 32'h0000BEEF, 1'b0);
        do_req("lh4",  1'b0, SZ_HALF, 1'b0, 10'd4, 32'h0, 32'h00005678, 1'b0);

        // illegal requests: no write, memory untouched
        wc = we_cnt;
        do_req("lw1",  1'b0, SZ_WORD, 1'b0, 10'd1, 32'h0, 32'h0, 1'b0);
        do_req("sh3",  1'b1, SZ_HALF, 1'b0, 10'd3, 32'h0000FFFF, 32'h0, 1'b0);
        do_req("sz11", 1'b1, 2'b11,   1'b0, 10'd8, 32'hCAFEF00D, 32'h0, 1'b0);
        chk("err_no_write", 32'(we_cnt), 32'(wc));
        do_req("lw4e", 1'b0, SZ_WORD, 1'b0, 10'd4, 32'h0, 32'hBEEF5678, 1'b0);
        do_req("lw0e", 1'b0, SZ_WORD, 1'b0, 10'd0, 32'h0, 32'h12805678, 1'b0);

        // requests presented while busy must be dropped
        do_req("sw100", 1'b1, SZ_WORD, 1'b0, 10'h100, 32'h00000000, 32'h0, 1'b0);
        do_req("lwpk",  1'b0, SZ_WORD, 1'b0, 10'd0, 32'h0, 32'h12805678, 1'b1);
        do_req("sbpk",  1'b1, SZ_BYTE, 1'b0, 10'h101, 32'h00000011, 32'h0, 1'b1);
        do_req("lw100", 1'b0, SZ_WORD, 1'b0, 10'h100, 32'h0, 32'h00001100, 1'b0);

        // top word, then reset in the middle of a read-modify-write
        do_req("sw1020", 1'b1, SZ_WORD, 1'b0, 10'd1020, 32'h00000000, 32'h0, 1'b0);
        do_req("sb1023", 1'b1, SZ_BYTE, 1'b0, 10'd1023, 32'h000000AA, 32'h0, 1'b0);
        do_req("lw1020", 1'b0, SZ_WORD, 1'b0, 10'd1020, 32'h0, 32'hAA000000, 1'b0);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_BYTE;
        bus.req_addr  = 10'd1020;
        bus.req_wdata = 32'h00000055;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("rmw_rd_addr", 32'(dm_addr), 32'd1020);
        wc = we_cnt;
        rst_n = 1'b0;
        #1;
        chk("arst_dm_we", 32'(dm_we), 32'h0);
        chk("arst_ready", 32'(bus.req_ready), 32'h1);
        chk("arst_dm_addr", 32'(dm_addr), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("arst_no_write", 32'(we_cnt), 32'(wc));
        chk("arst_ready_rel", 32'(bus.req_ready), 32'h1);
        chk("arst_resp_valid", 32'(bus.resp_valid), 32'h0);
        do_req("lw1020r", 1'b0, SZ_WORD, 1'b0, 10'd1020, 32'h0, 32'hAA000000, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
